pbvi_argmax_decider: RTL and testbench

- Sequential, parametrised POMDP action selector for the PBVI online-decision path.
- For each active alpha vector, computes the dot product of a latched belief with that vector and tracks the running maximum.
- Returns the action, value and index of the winning alpha vector.
- Streams alpha vectors from an external alpha/action memory (1-cycle read latency) instead of taking the full set as a wide bus, so depth is scalable.

---
 rtl/pbvi_pkg.sv | 25 ++
 rtl/pbvi_dot_product.sv | 54 +++++
 rtl/pbvi_argmax_decider.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_pbvi_argmax_decider.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pbvi_pkg.sv
// pbvi_pkg
// Shared definitions for the PBVI online-decision argmax block:
//   - default geometry (alpha-set depth, belief length, element and action widths)
//   - FSM state encoding of the decider
//   - accumulator-width helper so every user derives the same dot-product width
package pbvi_pkg;

    localparam int PBVI_N_ALPHA = 16;
    localparam int PBVI_N_STATE = 2;
    localparam int PBVI_W       = 16;
    localparam int PBVI_ACT_W   = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } pbvi_dec_state_t;

    // Signed(W) x unsigned(W) needs 2W+1 bits; summing n_state terms adds clog2 bits.
    function automatic int pbvi_acc_w(input int w, input int n_state);
        return 2 * w + 1 + $clog2(n_state);
    endfunction

endpackage

// File: rtl/pbvi_dot_product.sv
// pbvi_dot_product
// One dot product per cycle between a latched unsigned Q0.W belief and a signed
// alpha vector, with a registered result (one cycle of latency).
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous reset, active-high (clears the result register)
//   belief - N_STATE unsigned elements, element s at [s*W +: W]
//   alpha  - N_STATE signed elements, same packing
//   dot    - registered signed sum of element products, ACC_W bits
module pbvi_dot_product #(
    parameter int N_STATE = 2,
    parameter int W       = 16,
    parameter int ACC_W   = 34
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_STATE*W-1:0]    belief,
    input  logic [N_STATE*W-1:0]    alpha,
    output logic signed [ACC_W-1:0] dot
);

    localparam int PW = 2 * W + 1;

    logic signed [PW-1:0]    prod_s [N_STATE];
    logic signed [ACC_W-1:0] sum_s;
    logic signed [ACC_W-1:0] dot_r;

    // Element products: belief gets a zero sign bit so it multiplies as a non-negative value.
    always_comb begin
        for (int s = 0; s < N_STATE; s++) begin
            prod_s[s] = PW'($signed(alpha[s*W +: W])) * PW'($signed({1'b0, belief[s*W +: W]}));
        end
    end

    // Sign-extended sum of products; ACC_W is wide enough that it cannot overflow.
    always_comb begin
        sum_s = {ACC_W{1'b0}};
        for (int s = 0; s < N_STATE; s++) begin
            sum_s = sum_s + ACC_W'(prod_s[s]);
        end
    end

    // Result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dot_r <= {ACC_W{1'b0}};
        end else begin
            dot_r <= sum_s;
        end
    end

    assign dot = dot_r;

endmodule

// File: rtl/pbvi_argmax_decider.sv
// pbvi_argmax_decider
// Streams up to N_ALPHA alpha vectors from an external memory (1-cycle read
// latency), scores each against a latched belief and returns the action, value
// and index of the highest-scoring vector (ties keep the lowest index).
// Ports:
//   clk, rst         - clock (rising edge), asynchronous active-high reset
//   start            - decision request, honoured only when idle
//   n_active         - vectors to scan (clamped to N_ALPHA), latched at start
//   belief           - belief vector, latched at start
//   busy             - high from the cycle after start through the done cycle
//   alpha_rd_en/addr - memory read strobe and vector index
//   alpha_rd_data    - alpha vector, valid the cycle after alpha_rd_en
//   alpha_rd_action  - action tagged to that vector, same timing
//   done             - one-cycle pulse, results valid
//   result_valid     - at least one vector was scanned
//   action, best_value, best_index - winning vector, held until the next done
// Timing for N vectors accepted in cycle S: addresses in S+1..S+N, done in S+N+3
// (S+2 when N=0).
module pbvi_argmax_decider
    import pbvi_pkg::*;
#(
    parameter int N_ALPHA = PBVI_N_ALPHA,
    parameter int N_STATE = PBVI_N_STATE,
    parameter int W       = PBVI_W,
    parameter int ACT_W   = PBVI_ACT_W,
    parameter int IDX_W   = $clog2(N_ALPHA + 1),
    parameter int ACC_W   = pbvi_acc_w(W, N_STATE)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [IDX_W-1:0]        n_active,
    input  logic [N_STATE*W-1:0]    belief,
    output logic                    busy,
    output logic                    alpha_rd_en,
    output logic [IDX_W-1:0]        alpha_rd_addr,
    input  logic [N_STATE*W-1:0]    alpha_rd_data,
    input  logic [ACT_W-1:0]        alpha_rd_action,
    output logic                    done,
    output logic                    result_valid,
    output logic [ACT_W-1:0]        action,
    output logic signed [ACC_W-1:0] best_value,
    output logic [IDX_W-1:0]        best_index
);

    pbvi_dec_state_t state_r, state_nxt_s;

    logic                    accept_s, fetch_last_s, load_result_s;
    logic [IDX_W-1:0]        n_clamp_s, n_lat_r;
    logic [N_STATE*W-1:0]    belief_r;

    logic                    rd_en_r;
    logic [IDX_W-1:0]        rd_addr_r;

    logic                    vld0_r, vld1_r;
    logic [IDX_W-1:0]        idx0_r, idx1_r;
    logic [ACT_W-1:0]        act1_r;
    logic signed [ACC_W-1:0] dot_s;

    logic                    trk_have_r, trk_have_nxt_s;
    logic signed [ACC_W-1:0] trk_val_r, trk_val_nxt_s;
    logic [IDX_W-1:0]        trk_idx_r, trk_idx_nxt_s;
    logic [ACT_W-1:0]        trk_act_r, trk_act_nxt_s;

    logic                    busy_r, done_r, result_valid_r;
    logic [ACT_W-1:0]        action_r;
    logic signed [ACC_W-1:0] best_value_r;
    logic [IDX_W-1:0]        best_index_r;

    // Oversized requests scan the whole memory.
    always_comb begin
        if (n_active > IDX_W'(N_ALPHA)) begin
            n_clamp_s = IDX_W'(N_ALPHA);
        end else begin
            n_clamp_s = n_active;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic. DRAIN lasts one cycle: by FINISH the last vector sits
    // in the stage-1 register and the tracker's next-value logic folds it in.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (n_clamp_s == {IDX_W{1'b0}}) begin
                        state_nxt_s = ST_FINISH;
                    end else begin
                        state_nxt_s = ST_FETCH;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (fetch_last_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_DRAIN:  state_nxt_s = ST_FINISH;
            ST_FINISH: state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM control strobes. done is registered, so the done cycle is already IDLE;
    // done_r blocks a start in that cycle.
    always_comb begin
        accept_s      = 1'b0;
        fetch_last_s  = 1'b0;
        load_result_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && !done_r) begin
                    accept_s = 1'b1;
                end else begin
                    accept_s = 1'b0;
                end
            end
            ST_FETCH: begin
                if (rd_addr_r == (n_lat_r - IDX_W'(1))) begin
                    fetch_last_s = 1'b1;
                end else begin
                    fetch_last_s = 1'b0;
                end
            end
            ST_DRAIN:  load_result_s = 1'b0;
            ST_FINISH: load_result_s = 1'b1;
            default:   load_result_s = 1'b0;
        endcase
    end

    // Request latches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            belief_r <= {(N_STATE*W){1'b0}};
            n_lat_r  <= {IDX_W{1'b0}};
        end else if (accept_s) begin
            belief_r <= belief;
            n_lat_r  <= n_clamp_s;
        end else begin
            belief_r <= belief_r;
            n_lat_r  <= n_lat_r;
        end
    end

    // Read address generator: armed on accept so address 0 goes out in the first FETCH cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_en_r   <= 1'b0;
            rd_addr_r <= {IDX_W{1'b0}};
        end else if (accept_s) begin
            rd_en_r   <= (n_clamp_s != {IDX_W{1'b0}});
            rd_addr_r <= {IDX_W{1'b0}};
        end else if (state_r == ST_FETCH) begin
            if (fetch_last_s) begin
                rd_en_r   <= 1'b0;
                rd_addr_r <= {IDX_W{1'b0}};
            end else begin
                rd_en_r   <= 1'b1;
                rd_addr_r <= rd_addr_r + IDX_W'(1);
            end
        end else begin
            rd_en_r   <= 1'b0;
            rd_addr_r <= {IDX_W{1'b0}};
        end
    end

    pbvi_dot_product #(
        .N_STATE (N_STATE),
        .W       (W),
        .ACC_W   (ACC_W)
    ) u_dot (
        .clk    (clk),
        .rst    (rst),
        .belief (belief_r),
        .alpha  (alpha_rd_data),
        .dot    (dot_s)
    );

    // Valid/index/action pipeline aligned with read data (stage 0) and dot result (stage 1).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld0_r <= 1'b0;
            idx0_r <= {IDX_W{1'b0}};
            vld1_r <= 1'b0;
            idx1_r <= {IDX_W{1'b0}};
            act1_r <= {ACT_W{1'b0}};
        end else begin
            vld0_r <= rd_en_r;
            idx0_r <= rd_addr_r;
            vld1_r <= vld0_r;
            idx1_r <= idx0_r;
            act1_r <= alpha_rd_action;
        end
    end

    // Argmax next value: first vector seeds, later ones must be strictly greater.
    always_comb begin
        trk_have_nxt_s = trk_have_r;
        trk_val_nxt_s  = trk_val_r;
        trk_idx_nxt_s  = trk_idx_r;
        trk_act_nxt_s  = trk_act_r;
        if (vld1_r && (!trk_have_r || (dot_s > trk_val_r))) begin
            trk_have_nxt_s = 1'b1;
            trk_val_nxt_s  = dot_s;
            trk_idx_nxt_s  = idx1_r;
            trk_act_nxt_s  = act1_r;
        end else begin
            trk_have_nxt_s = trk_have_r;
            trk_val_nxt_s  = trk_val_r;
            trk_idx_nxt_s  = trk_idx_r;
            trk_act_nxt_s  = trk_act_r;
        end
    end

    // Argmax tracker register, cleared per decision so an empty scan reports zeros.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trk_have_r <= 1'b0;
            trk_val_r  <= {ACC_W{1'b0}};
            trk_idx_r  <= {IDX_W{1'b0}};
            trk_act_r  <= {ACT_W{1'b0}};
        end else if (accept_s) begin
            trk_have_r <= 1'b0;
            trk_val_r  <= {ACC_W{1'b0}};
            trk_idx_r  <= {IDX_W{1'b0}};
            trk_act_r  <= {ACT_W{1'b0}};
        end else begin
            trk_have_r <= trk_have_nxt_s;
            trk_val_r  <= trk_val_nxt_s;
            trk_idx_r  <= trk_idx_nxt_s;
            trk_act_r  <= trk_act_nxt_s;
        end
    end

    // Output registers: results load at the end of FINISH and become visible with done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            result_valid_r <= 1'b0;
            action_r       <= {ACT_W{1'b0}};
            best_value_r   <= {ACC_W{1'b0}};
            best_index_r   <= {IDX_W{1'b0}};
        end else begin
            done_r <= load_result_s;
            if (accept_s) begin
                busy_r <= 1'b1;
            end else if (done_r) begin
                busy_r <= 1'b0;
            end else begin
                busy_r <= busy_r;
            end
            if (load_result_s) begin
                result_valid_r <= (n_lat_r != {IDX_W{1'b0}});
                action_r       <= trk_act_nxt_s;
                best_value_r   <= trk_val_nxt_s;
                best_index_r   <= trk_idx_nxt_s;
            end else begin
                result_valid_r <= result_valid_r;
                action_r       <= action_r;
                best_value_r   <= best_value_r;
                best_index_r   <= best_index_r;
            end
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign alpha_rd_en   = rd_en_r;
    assign alpha_rd_addr = rd_addr_r;
    assign result_valid  = result_valid_r;
    assign action        = action_r;
    assign best_value    = best_value_r;
    assign best_index    = best_index_r;

endmodule

// File: tb/tb_pbvi_argmax_decider.sv
// tb_pbvi_argmax_decider
// Self-checking bench: a 1-cycle-latency alpha memory model, a cycle-window
// model of busy/done/read strobes plus a plain-arithmetic argmax reference,
// checked every cycle at the falling edge, and literal checks on directed cases.
module tb_pbvi_argmax_decider;
    import pbvi_pkg::*;

    localparam int N_ALPHA = PBVI_N_ALPHA;
    localparam int N_STATE = PBVI_N_STATE;
    localparam int W       = PBVI_W;
    localparam int ACT_W   = PBVI_ACT_W;
    localparam int IDX_W   = $clog2(N_ALPHA + 1);
    localparam int ACC_W   = pbvi_acc_w(W, N_STATE);

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    start = 1'b0;
    logic [IDX_W-1:0]        n_active = '0;
    logic [N_STATE*W-1:0]    belief = '0;
    logic                    busy, alpha_rd_en, done, result_valid;
    logic [IDX_W-1:0]        alpha_rd_addr, best_index;
    logic [N_STATE*W-1:0]    alpha_rd_data = '0;
    logic [ACT_W-1:0]        alpha_rd_action = '0;
    logic [ACT_W-1:0]        action;
    logic signed [ACC_W-1:0] best_value;

    int mem_a [N_ALPHA][N_STATE];
    int mem_act [N_ALPHA];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    pbvi_argmax_decider dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .n_active        (n_active),
        .belief          (belief),
        .busy            (busy),
        .alpha_rd_en     (alpha_rd_en),
        .alpha_rd_addr   (alpha_rd_addr),
        .alpha_rd_data   (alpha_rd_data),
        .alpha_rd_action (alpha_rd_action),
        .done            (done),
        .result_valid    (result_valid),
        .action          (action),
        .best_value      (best_value),
        .best_index      (best_index)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Alpha/action memory with one cycle of read latency.
    always @(posedge clk) begin
        if (alpha_rd_en && (int'(alpha_rd_addr) < N_ALPHA)) begin
            for (int s = 0; s < N_STATE; s++) begin
                alpha_rd_data[s*W +: W] <= W'(mem_a[alpha_rd_addr][s]);
            end
            alpha_rd_action <= ACT_W'(mem_act[alpha_rd_addr]);
        end
    end

    task automatic chk(input string name, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, exp);
        end
    endtask

    // Reference decision: score every vector, keep the first strictly greater one.
    function automatic void ref_argmax(input int n, input logic [N_STATE*W-1:0] b,
                                       output longint val, output int idx, output int act);
        longint v;
        val = 0; idx = 0; act = 0;
        for (int i = 0; i < n; i++) begin
            v = 0;
            for (int s = 0; s < N_STATE; s++) begin
                v += longint'(mem_a[i][s]) * longint'(b[s*W +: W]);
            end
            if (i == 0 || v > val) begin
                val = v; idx = i; act = mem_act[i];
            end
        end
    endfunction

    // Model state: active decision window and pending / visible results.
    bit     m_act = 1'b0;
    int     m_S, m_D, m_N;
    bit     r_rv, h_rv;
    longint r_val, h_val;
    int     r_idx, r_actn, h_idx, h_actn;
    bit     win, is_done, rd_exp;

    // Compare process: every falling edge.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_rd_en", alpha_rd_en, 0);
            chk("rst_result_valid", result_valid, 0);
            chk("rst_action", action, 0);
            chk("rst_best_value", best_value, 0);
            chk("rst_best_index", best_index, 0);
            m_act = 1'b0;
            h_rv = 1'b0; h_val = 0; h_idx = 0; h_actn = 0;
        end else begin
            win     = m_act && (cyc >= m_S + 1) && (cyc <= m_D);
            is_done = m_act && (cyc == m_D);
            rd_exp  = m_act && (m_N > 0) && (cyc >= m_S + 1) && (cyc <= m_S + m_N);
            if (is_done) begin
                h_rv = r_rv; h_val = r_val; h_idx = r_idx; h_actn = r_actn;
            end
            chk("busy", busy, win);
            chk("done", done, is_done);
            chk("rd_en", alpha_rd_en, rd_exp);
            if (rd_exp) chk("rd_addr", alpha_rd_addr, cyc - m_S - 1);
            chk("result_valid", result_valid, h_rv);
            chk("action", action, h_actn);
            chk("best_value", best_value, h_val);
            chk("best_index", best_index, h_idx);
            if (start && !win) begin
                m_S = cyc;
                m_N = (int'(n_active) > N_ALPHA) ? N_ALPHA : int'(n_active);
                m_D = (m_N == 0) ? cyc + 2 : cyc + m_N + 3;
                ref_argmax(m_N, belief, r_val, r_idx, r_actn);
                r_rv  = (m_N != 0);
                m_act = 1'b1;
            end
        end
    end

    task automatic set_row(input int i, input int a0, input int a1, input int ac);
        mem_a[i][0] = a0; mem_a[i][1] = a1; mem_act[i] = ac;
    endtask

    task automatic rand_mem();
        for (int i = 0; i < N_ALPHA; i++) begin
            for (int s = 0; s < N_STATE; s++) mem_a[i][s] = int'($urandom_range(0, 65535)) - 32768;
            mem_act[i] = int'($urandom_range(0, 3));
        end
    endtask

    task automatic pulse_start(input int n, input logic [N_STATE*W-1:0] b, output int s);
        @(posedge clk); #2;
        n_active = IDX_W'(n); belief = b; start = 1'b1; s = cyc;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(output int d);
        d = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done) begin
                d = cyc;
                return;
            end
        end
        errors++;
        $display("FAIL wait_done: no done within 200 cycles");
    endtask

    localparam logic [N_STATE*W-1:0] B_HALF = {16'h8000, 16'h8000};

    initial begin
        int s, d, d2;
        logic [N_STATE*W-1:0] b;
        for (int i = 0; i < N_ALPHA; i++) set_row(i, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Directed: row 2 wins.
        set_row(0, 100, 100, 0); set_row(1, 300, -100, 1);
        set_row(2, 50, 400, 2);  set_row(3, 0, 0, 3);
        pulse_start(4, B_HALF, s); wait_done(d);
        chk("lat_n4", d - s, 7);
        chk("A_index", best_index, 2); chk("A_action", action, 2);
        chk("A_value", best_value, 64'sd14745600); chk("A_valid", result_valid, 1);

        // Tie between rows 1 and 3: lowest index wins.
        set_row(0, 10, 10, 0); set_row(1, 200, 0, 1);
        set_row(2, 0, 150, 2); set_row(3, 100, 100, 3);
        pulse_start(4, B_HALF, s); wait_done(d);
        chk("tie_index", best_index, 1); chk("tie_action", action, 1);
        chk("tie_value", best_value, 64'sd6553600);

        // All negative scores.
        set_row(0, -5, -5, 2); set_row(1, -1, -1, 3);
        pulse_start(2, B_HALF, s); wait_done(d);
        chk("neg_index", best_index, 1); chk("neg_action", action, 3);
        chk("neg_value", best_value, -64'sd65536);

        // Empty scan.
        pulse_start(0, B_HALF, s); wait_done(d);
        chk("lat_n0", d - s, 2);
        chk("empty_valid", result_valid, 0); chk("empty_value", best_value, 0);
        chk("empty_index", best_index, 0); chk("empty_action", action, 0);

        // Reset in the middle of a full scan, then a clean run.
        rand_mem();
        pulse_start(16, {16'h1234, 16'hfedc}, s);
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0); chk("mid_rst_rd_en", alpha_rd_en, 0);
        chk("mid_rst_value", best_value, 0); chk("mid_rst_valid", result_valid, 0);
        @(posedge clk); #2 rst = 1'b0;
        pulse_start(16, {16'h4321, 16'h0fed}, s); wait_done(d);
        chk("lat_after_rst", d - s, 19);

        // Full depth, oversized n_active, start held high through the scan and the done cycle.
        rand_mem();
        set_row(5, 32767, 32767, 1); set_row(9, -32768, -32768, 2);
        b = {W'($urandom), W'($urandom)};
        @(posedge clk); #2;
        n_active = IDX_W'(31); belief = b; start = 1'b1; s = cyc;
        wait_done(d);
        chk("lat_clamped", d - s, 19);
        @(posedge clk); #2;
        belief = {W'($urandom), W'($urandom)};
        @(posedge clk); #2;
        start = 1'b0;
        wait_done(d2);
        chk("back_to_back", d2 - (d + 1), 19);

        // Second random full scan with fresh data.
        rand_mem();
        pulse_start(16, {W'($urandom), W'($urandom)}, s); wait_done(d);
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
